// File: rtl/lsr_iter_if.sv
// Request/response bundle for the iterative logical-shift-right unit.
// The issuing stage is the master; lsr_iter is the slave.
interface lsr_iter_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int SHAMT_WIDTH = 6
);
  logic                   start;
  logic [DATA_WIDTH-1:0]  in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  out;

  modport master (output start, in, shamt, input  busy, done, out);
  modport slave  (input  start, in, shamt, output busy, done, out);
endinterface

// File: rtl/lsr_iter.sv
// Iterative logical shift right: retires up to two bit positions per clock,
// zero-fills vacated MSBs, and reports the result with a one-cycle done pulse.
module lsr_iter #(
  parameter int DATA_WIDTH  = 64,
  parameter int SHAMT_WIDTH = 6
) (
  input  logic     clk,
  input  logic     reset_n,
  lsr_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc, acc_d;
  logic [SHAMT_WIDTH-1:0] cnt, cnt_d;
  logic [DATA_WIDTH-1:0]  out_q;

  // Next-state and datapath update; start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    cnt_d   = cnt;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.in;
          cnt_d   = bus.shamt;
          state_d = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // Two positions when available, otherwise the final odd position;
        // cnt therefore lands exactly on zero and never wraps.
        if (cnt >= SHAMT_WIDTH'(2)) begin
          acc_d = acc >> 2;
          cnt_d = cnt - SHAMT_WIDTH'(2);
        end else begin
          acc_d = acc >> 1;
          cnt_d = '0;
        end
        if (cnt_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; result is latched on the edge entering DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      if (state_d == DONE) out_q <= acc_d;
    end
  end

  // Status decoded purely from registered state.
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;

endmodule
